// File: rtl/uart_rx_pkg.sv
// Common constants and helpers for the UART receiver.
package uart_rx_pkg;
    localparam int         DATA_BITS = 8;
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
endpackage

// File: rtl/baudgen.vh
// Shared baud-rate constants: clock cycles per bit period at a 12 MHz system clock.
`ifndef BAUDGEN_VH
`define BAUDGEN_VH
`define B115200 104
`define B57600  208
`define B38400  313
`define B19200  625
`define B9600   1250
`define B4800   2500
`endif

// File: rtl/baudgen_rx.sv
// Receive-side baud tick: first pulse BAUD/2 cycles after clk_ena rises, then every BAUD cycles.
`include "baudgen.vh"
module baudgen_rx #(
    parameter int BAUD = `B115200
) (
    input  logic clk,
    input  logic clk_ena,
    output logic clk_out
);
    localparam int            CW   = (BAUD > 2) ? $clog2(BAUD) : 2;
    localparam logic [CW-1:0] HALF = CW'(BAUD / 2);
    localparam logic [CW-1:0] LAST = CW'(BAUD - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt;

    // Counter sits at 0 whenever disabled, so each enable restarts the half-bit offset.
    always_ff @(posedge clk) begin
        if (!clk_ena)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + ONE;
    end

    assign clk_out = clk_ena && (cnt == HALF);
endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver, LSB first, one stop bit.
// Optional even parity bit when UART_RX_PARITY_EN is defined; otherwise perr is tied low.
`include "baudgen.vh"
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD = `B115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       perr
);
    // state     | meaning
    // IDLE      | line idle, waiting for rx_s low
    // START     | checking start bit at its mid-point
    // DATA      | shifting in 8 data bits
    // PARITY    | sampling the even-parity bit (parity build only)
    // STOP      | sampling the stop bit
    // DONE      | one cycle, rcv high with the new byte
    // WAIT_IDLE | line still low after the frame (break), wait for high
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE, WAIT_IDLE} state_t;
`endif

    state_t                 state, next_state;
    logic                   rx_meta, rx_s;
    logic [DATA_BITS-1:0]   shift;
    logic [3:0]             bit_cnt;
    logic                   tick;
    logic                   clk_ena;

    baudgen_rx #(.BAUD(BAUD)) u_baudgen (
        .clk     (clk),
        .clk_ena (clk_ena),
        .clk_out (tick)
    );

`ifdef UART_RX_PARITY_EN
    assign clk_ena = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
`else
    assign clk_ena = (state == START) || (state == DATA) || (state == STOP);
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (!rx_s) next_state = START;
            START:     if (tick) next_state = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:      if (tick && bit_cnt == LAST_BIT) next_state = PARITY;
            PARITY:    if (tick) next_state = STOP;
`else
            DATA:      if (tick && bit_cnt == LAST_BIT) next_state = STOP;
`endif
            STOP:      if (tick) next_state = DONE;
            DONE:      next_state = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic perr_q;
    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    // Result registers load as DONE is entered, so data/ferr/perr are valid while rcv is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
            data    <= '0;
            rcv     <= 1'b0;
            ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rcv     <= 1'b0;
            if (state == IDLE)
                bit_cnt <= '0;
            if (tick) begin
                case (state)
                    DATA: begin
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: par_bit <= rx_s;
`endif
                    STOP: begin
                        data <= shift;
                        ferr <= ~rx_s;
                        rcv  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_q <= par_bit ^ even_parity(shift);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed bench for uart_rx at BAUD=104, checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int BAUD = 104;
`ifdef UART_RX_PARITY_EN
    localparam int NPOST = 10;
`else
    localparam int NPOST = 9;
`endif
    // Start edge on rx to rcv: 2 sync flops, 1 cycle to leave IDLE, half a bit to the
    // start mid-point, NPOST more bit periods to the stop mid-point, then 1 cycle.
    localparam int LAT = 3 + BAUD / 2 + NPOST * BAUD + 1;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       perr;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    ev_t exp_q[$];
    ev_t got_q[$];
    logic [7:0] last_d;

    uart_rx #(.BAUD(BAUD)) dut (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .data (data),
        .rcv  (rcv),
        .ferr (ferr),
        .perr (perr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rcv === 1'b1)
            got_q.push_back('{cyc, data, ferr, perr});
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input int stop_len, input logic par_flip);
        int  s;
        logic pe;
        s  = cyc;
        pe = 1'b0;
        drive(1'b0, BAUD);
        for (int i = 0; i < 8; i++)
            drive(d[i], BAUD);
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ par_flip, BAUD);
        pe = par_flip;
`endif
        drive(stop_v, stop_len * BAUD);
        exp_q.push_back('{s + LAT, d, ~stop_v, pe});
        last_d = d;
    endtask

    task automatic flush(input string tag);
        ev_t e, g;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({tag, "_cycle"}, g.cyc, e.cyc);
            chk({tag, "_data"},  int'(g.d),  int'(e.d));
            chk({tag, "_ferr"},  int'(g.fe), int'(e.fe));
            chk({tag, "_perr"},  int'(g.pe), int'(e.pe));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       fe, pf;
        int         gap;

        rst = 1'b0;
        rx  = 1'b1;
        last_d = 8'h00;
        repeat (5) @(negedge clk);
        chk("rst_data", int'(data), 0);
        chk("rst_rcv",  int'(rcv),  0);
        chk("rst_ferr", int'(ferr), 0);
        chk("rst_perr", int'(perr), 0);
        rst = 1'b1;
        idle(20);

        send_frame(8'h55, 1'b1, 1, 1'b0);
        idle(BAUD);
        flush("f55");

        drive(1'b0, 20);
        idle(3 * BAUD);
        flush("false_start");
        chk("hold_data", int'(data), int'(last_d));

        send_frame(8'hA5, 1'b0, 3, 1'b0);
        idle(BAUD);
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        idle(BAUD);
        flush("break");

        send_frame(8'hA5, 1'b1, 1, 1'b0);
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        idle(BAUD);
        flush("b2b");

        // Abort a 0xAA frame during data bit 4 and leave the line idle.
        d = 8'hAA;
        drive(1'b0, BAUD);
        for (int i = 0; i < 4; i++)
            drive(d[i], BAUD);
        drive(d[4], BAUD / 2);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rx  = 1'b1;
        rst = 1'b1;
        idle(10 * BAUD);
        flush("abort");
        chk("abort_data", int'(data), 0);
        chk("abort_ferr", int'(ferr), 0);
        send_frame(8'hFF, 1'b1, 1, 1'b0);
        idle(BAUD);
        flush("after_abort");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1, 1'b1);
        idle(BAUD);
        flush("par_bad");
        send_frame(8'h03, 1'b1, 1, 1'b0);
        idle(BAUD);
        flush("par_good");
`endif

        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            fe = ($urandom_range(3) == 0);
            pf = 1'b0;
`ifdef UART_RX_PARITY_EN
            pf = ($urandom_range(3) == 0);
`endif
            send_frame(d, ~fe, fe ? 1 + int'($urandom_range(2)) : 1, pf);
            gap = fe ? BAUD + int'($urandom_range(200)) : int'($urandom_range(200));
            idle(gap);
            flush("rand");
            chk("rand_hold", int'(data), int'(last_d));
        end

        idle(BAUD);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD, default `B115200, clock cycles per bit period (104 at 12 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port data  output  8  last received byte, registered.
REQ-006 SHALL have port rcv  output  1  one-cycle strobe: new byte valid on data.
REQ-007 SHALL have port ferr  output  1  frame error flag for the byte strobed by rcv.
REQ-008 SHALL have port perr  output  1  parity error flag for the byte strobed by rcv.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-010 SHALL define the frame as: start bit 0, data bits 0-7 LSB first, optional parity bit, stop bit 1.
REQ-011 SHALL use the FSM states IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE.
REQ-012 SHALL move from IDLE to START on the first cycle rx_s is 0, and enable the baud counter from 0.
REQ-013 SHALL produce a sample tick at cycle BAUD/2 (integer division) after the counter is enabled, then every BAUD cycles.
REQ-014 SHALL return to IDLE from START if rx_s is 1 at the first tick (false start), with no rcv strobe.
REQ-015 SHALL shift in rx_s on each of 8 ticks in DATA, using a 4-bit counter to count the bits.
REQ-016 SHALL take parity from the next tick in PARITY, only when the parity option is enabled.
REQ-017 SHALL sample the stop bit on the next tick in STOP, then enter DONE.
REQ-018 SHALL, in DONE (exactly 1 cycle), load data from the shift register and update ferr and perr.
REQ-019 SHALL assert rcv exactly 1 cycle after the stop-bit tick.
REQ-020 SHALL set ferr=1 when the stop bit is 0, and still load data and pulse rcv.
REQ-021 SHALL go from DONE to IDLE when rx_s is 1, and otherwise to WAIT_IDLE until rx_s is 1, so a break condition never retriggers.
REQ-022 SHALL hold data, ferr and perr stable from one rcv to the next; no consumer handshake exists.
REQ-023 SHALL accept back-to-back frames: a falling edge seen in the cycle IDLE is re-entered starts a new frame.
REQ-024 SHALL disable the baud counter and hold it at 0 in IDLE, DONE and WAIT_IDLE.

Reset
REQ-025 SHALL, while rst==0 at a clock edge, set state=IDLE, data=8'h00, rcv=0, ferr=0, perr=0, synchronizer flops=1, shift and bit counters=0, and stop the baud counter.
REQ-026 SHALL abandon a frame in progress when reset is asserted mid-frame; no rcv SHALL follow for the aborted frame.

Configuration
REQ-027 SHALL, with UART_RX_PARITY_EN defined, expect an even-parity bit after data bit 7 and set perr=1 in DONE on mismatch.
REQ-028 SHALL, without UART_RX_PARITY_EN, omit the PARITY state and tie perr to 0; ports are identical in both builds.

Structure
REQ-029 SHALL take baud constants (`B115200 etc.) from the shared header baudgen.vh; FSM state encodings are local to uart_rx.
REQ-030 SHALL implement the baud timing in the sub-module baudgen_rx (ports clk, clk_ena, clk_out; first pulse at BAUD/2, then every BAUD).

Verification (BAUD=104)
REQ-031 SHALL verify: frame 0x55 with valid stop -> one rcv pulse, data=0x55, ferr=0, rcv 1 cycle after the stop-bit mid-point.
REQ-032 SHALL verify: rx low for 20 cycles, then high -> no rcv, FSM back in IDLE.
REQ-033 SHALL verify: 0xA5 with stop bit 0 held low for 3 bit periods -> rcv, data=0xA5, ferr=1, then a single 0x3C frame after the line goes high -> rcv, data=0x3C, ferr=0.
REQ-034 SHALL verify: 0xA5 then 0x3C with no idle gap -> two rcv pulses, data 0xA5 then 0x3C.
REQ-035 SHALL verify: rst=0 during data bit 4 -> data=0x00, no rcv; the next 0xFF frame is received correctly.
REQ-036 SHALL verify (UART_RX_PARITY_EN): 0x03 with parity bit 1 -> perr=1; with parity bit 0 -> perr=0.
